seg7_scanner: RTL and testbench

- Downstream display stage for the CPU statistics counters (cycle/instruction counts).
- Takes a binary counter value and time-multiplexes it as hexadecimal onto an 8-digit common-anode seven-segment display.
- Snapshots the value once per scan frame, so a running counter does not tear across digits.
- Supports freezing the displayed value and blanking leading zeros.

---
 rtl/seg7_scanner_pkg.sv | 18 +
 rtl/seg7_scanner_hex7seg.sv | 15 +
 rtl/seg7_scanner.sv | 95 +++++++++
 tb/tb_seg7_scanner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg7_scanner_pkg.sv
// Shared constants for the seven-segment scanner.
//   HEX_SEG          : nibble -> active-low cathode code, bit order g..a
//   SEG_OFF          : all cathodes off
//   SCAN_DIV_DEFAULT : default refresh divider width
package seg7_scanner_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT = 17;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scanner_hex7seg.sv
// Combinational hex digit decoder.
//   nib : 4-bit value to show
//   seg : active-low cathodes, seg[0]=a .. seg[6]=g
module hex7seg
  import seg7_scanner_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed hexadecimal display driver for an N-digit common-anode
// seven-segment display. The input value is snapshotted once per scan frame
// so a running counter never tears across digits.
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   value      : counter value to display (4*DIGITS bits)
//   hold       : 1 = keep current snapshot, ignore value
//   dp_mask    : per-digit decimal point enable (1 = lit)
//   an         : digit enables, active low (one low, or all high)
//   seg        : cathodes, active low, seg[0]=a .. seg[6]=g
//   dp         : decimal point, active low
//   frame_tick : one-cycle pulse at each frame start
module seg7_scanner
  import seg7_scanner_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  hold,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int          IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ND   = DIGITS;

  logic [SCAN_DIV-1:0]  div;
  logic [IDXW-1:0]      idx;
  logic [4*DIGITS-1:0]  snap;
  logic [4*DIGITS-1:0]  snap_next;
  logic                 frame_start;
  logic [3:0]           nib;
  logic [6:0]           nib_seg;
  logic                 hi_zero;
  logic                 blank;
  logic [DIGITS-1:0]    an_next;

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (nib_seg)
  );

  always_comb begin
    frame_start = (div == '0) && (idx == '0);
    snap_next   = (frame_start && !hold) ? value : snap;
    nib         = snap_next[4*idx +: 4];
    an_next     = ~(DIGITS'(1) << idx);

    // The current digit is a leading zero when it and every digit above it
    // are zero; digit 0 always stays lit so a zero value still shows "0".
    hi_zero = 1'b1;
    for (int unsigned i = 0; i < ND; i++) begin
      if ((i >= 32'(idx)) && (snap_next[4*i +: 4] != 4'h0)) begin
        hi_zero = 1'b0;
      end
    end
    blank = (BLANK_LZ != 0) && (idx != '0) && hi_zero;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div        <= '0;
      idx        <= '0;
      snap       <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      div        <= div + 1'b1;
      snap       <= snap_next;
      frame_tick <= frame_start;
      if (div == '1) begin
        idx <= (idx == IDXW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      if (blank) begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= an_next;
        seg <= nib_seg;
        dp  <= ~dp_mask[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
module tb_seg7_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value;
  logic        hold;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scanner #(
    .DIGITS   (8),
    .SCAN_DIV (2),
    .BLANK_LZ (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .hold       (hold),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     value;
    logic            hold;
    logic [7:0]      dp_mask;
    logic [7:0][6:0] segs;   // expected code per digit, [7] first in literal
    logic [7:0]      lit;    // digits expected to be driven (not blanked)
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for the negedge on which frame_tick is high.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_tick: got no frame_tick expected one within 40 cycles");
    end
  endtask

  // Checks the 32 cycles of a frame; first cycle is the current negedge.
  task automatic check_frame(input int v);
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d;
    for (int k = 0; k < 32; k++) begin
      if (k != 0) @(negedge clk);
      d = k / 4;
      if (vecs[v].lit[d]) begin
        e_an  = ~(8'h01 << d);
        e_seg = vecs[v].segs[d];
        e_dp  = ~vecs[v].dp_mask[d];
      end else begin
        e_an  = 8'hFF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      chk($sformatf("v%0d_k%0d_an", v, k), 32'(an), 32'(e_an));
      chk($sformatf("v%0d_k%0d_seg", v, k), 32'(seg), 32'(e_seg));
      chk($sformatf("v%0d_k%0d_dp", v, k), 32'(dp), 32'(e_dp));
      chk($sformatf("v%0d_k%0d_tick", v, k), 32'(frame_tick), (k == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    bit ok;
    int gap;

    vecs[0] = '{32'h0000_0000, 1'b0, 8'h00,
                {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'h01};
    vecs[1] = '{32'h0123_4567, 1'b0, 8'h00,
                {7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78}, 8'h7F};
    // hold across frame start: still the previous snapshot
    vecs[2] = '{32'hDEAD_BEEF, 1'b1, 8'h00,
                {7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78}, 8'h7F};
    vecs[3] = '{32'hDEAD_BEEF, 1'b0, 8'h00,
                {7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E}, 8'hFF};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 8'h04,
                {7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E}, 8'hFF};
    vecs[5] = '{32'h0000_0100, 1'b0, 8'h00,
                {7'h40,7'h40,7'h40,7'h40,7'h40,7'h79,7'h40,7'h40}, 8'h07};
    vecs[6] = '{32'h8000_0000, 1'b0, 8'h81,
                {7'h00,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'hFF};

    rst_n   = 1'b0;
    value   = 32'h0;
    hold    = 1'b0;
    dp_mask = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_tick", 32'(frame_tick), 32'h0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_an", 32'(an), 32'hFE);
    chk("rel_seg", 32'(seg), 32'h40);
    chk("rel_tick", 32'(frame_tick), 32'h1);

    for (int v = 0; v < 7; v++) begin
      value   = vecs[v].value;
      hold    = vecs[v].hold;
      dp_mask = vecs[v].dp_mask;
      wait_tick(ok);
      if (ok) check_frame(v);
    end

    // Mid-frame reset at cycle 13 of a frame.
    hold  = 1'b0;
    value = 32'h0000_0005;
    wait_tick(ok);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_an", 32'(an), 32'hFF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'h1);
    chk("mid_rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tick", 32'(frame_tick), 32'h1);
    chk("post_rst_an", 32'(an), 32'hFE);
    chk("post_rst_seg", 32'(seg), 32'h12);

    // Tick period after reset: next tick exactly 32 cycles later.
    gap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gap++;
      if (frame_tick) break;
    end
    chk("tick_period", 32'(gap), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
